// File: rtl/vsu_op_sched_if.sv
// Bundle between the VSU operand scheduler and its environment: store request,
// per-lane VRF read requests, credit returns, completion and debug visibility.
interface vsu_op_sched_if #(
  parameter int unsigned NrLane       = 4,
  parameter int unsigned InOpBufDepth = 4,
  parameter int unsigned VlBWidth     = 16,
  parameter int unsigned IdWidth      = 3
);
  localparam int unsigned CreditW = $clog2(InOpBufDepth + 1);

  // Handshakes: a transfer happens in a cycle where valid and ready are both
  // high; valid never depends on ready, and ready may depend on valid only on
  // the acceptor side. Each rd lane is an independent valid/ready pair.
  logic                               req_valid_i;
  logic                               req_ready_o;
  logic [4:0]                         req_vs_i;
  logic [VlBWidth-1:0]                req_vlB_i;
  logic [IdWidth-1:0]                 req_id_i;
  logic [NrLane-1:0]                  rd_valid_o;
  logic [NrLane-1:0]                  rd_ready_i;
  logic [4:0]                         rd_vreg_o;
  logic [NrLane-1:0][VlBWidth-1:0]    rd_off_o;
  logic [NrLane-1:0]                  op_pop_i;
  logic                               issue_done_o;
  logic [IdWidth-1:0]                 issue_id_o;
  logic                               busy_o;
  logic                               dbg_state_o;
  logic [NrLane-1:0][CreditW-1:0]     dbg_credit_o;

  modport slave (
    input  req_valid_i, req_vs_i, req_vlB_i, req_id_i, rd_ready_i, op_pop_i,
    output req_ready_o, rd_valid_o, rd_vreg_o, rd_off_o, issue_done_o,
           issue_id_o, busy_o, dbg_state_o, dbg_credit_o
  );

  modport master (
    output req_valid_i, req_vs_i, req_vlB_i, req_id_i, rd_ready_i, op_pop_i,
    input  req_ready_o, rd_valid_o, rd_vreg_o, rd_off_o, issue_done_o,
           issue_id_o, busy_o, dbg_state_o, dbg_credit_o
  );
endinterface

// File: rtl/vsu_op_sched.sv
// VSU operand scheduler: splits a vector store into per-lane VRF row reads,
// gated by per-lane credits mirroring the VSU operand FIFO occupancy.
module vsu_op_sched #(
  parameter int unsigned NrLane       = 4,
  parameter int unsigned InOpBufDepth = 4,
  parameter int unsigned LaneWordB    = 8,
  parameter int unsigned VlBWidth     = 16,
  parameter int unsigned IdWidth      = 3
) (
  input logic            clk_i,
  input logic            rst_ni,
  vsu_op_sched_if.slave  bus
);
  localparam int unsigned RowBytes = NrLane * LaneWordB;
  localparam int unsigned RowShift = $clog2(RowBytes);
  localparam int unsigned CreditW  = $clog2(InOpBufDepth + 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e                           state_q;
  logic [4:0]                       vs_q;
  logic [IdWidth-1:0]               id_q;
  logic [VlBWidth:0]                rows_q;
  logic [VlBWidth:0]                rows_new;
  logic [NrLane-1:0][VlBWidth:0]    row_q;
  logic [NrLane-1:0][CreditW-1:0]   credit_q;
  logic [NrLane-1:0]                rd_valid;
  logic [NrLane-1:0]                rd_hs;
  logic [NrLane-1:0]                lane_done;
  logic                             all_done;
  logic                             req_ready;
  logic                             req_hs;

  // Ceiling divide by the row size; one extra bit keeps vlB near max from wrapping.
  always_comb begin
    rows_new = ({1'b0, bus.req_vlB_i} + (VlBWidth+1)'(RowBytes - 1)) >> RowShift;
    for (int i = 0; i < NrLane; i++) begin
      lane_done[i] = (row_q[i] == rows_q);
      rd_valid[i]  = (state_q == ISSUE) && (row_q[i] < rows_q) && (credit_q[i] != '0);
    end
    rd_hs     = rd_valid & bus.rd_ready_i;
    all_done  = (state_q == ISSUE) && (&lane_done);
    req_ready = (state_q == IDLE) || all_done;
    req_hs    = bus.req_valid_i && req_ready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rows_q  <= '0;
      row_q   <= '0;
    end else if (req_hs) begin
      state_q <= ISSUE;
      rows_q  <= rows_new;
      row_q   <= '0;
    end else if (all_done) begin
      state_q <= IDLE;
    end else begin
      for (int i = 0; i < NrLane; i++) begin
        if (rd_hs[i]) row_q[i] <= row_q[i] + (VlBWidth+1)'(1);
      end
    end
  end

  // Instruction tags are only observed while their valids are high.
  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      vs_q <= bus.req_vs_i;
      id_q <= bus.req_id_i;
    end
  end

  // Credits track free slots in each lane FIFO and survive across instructions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrLane; i++) credit_q[i] <= CreditW'(InOpBufDepth);
    end else begin
      for (int i = 0; i < NrLane; i++) begin
        if (rd_hs[i] && !bus.op_pop_i[i]) begin
          credit_q[i] <= credit_q[i] - CreditW'(1);
        end else if (!rd_hs[i] && bus.op_pop_i[i] &&
                     (credit_q[i] < CreditW'(InOpBufDepth))) begin
          credit_q[i] <= credit_q[i] + CreditW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NrLane; i++) bus.rd_off_o[i] = row_q[i][VlBWidth-1:0];
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.rd_valid_o   = rd_valid;
  assign bus.rd_vreg_o    = vs_q;
  assign bus.issue_done_o = all_done;
  assign bus.issue_id_o   = id_q;
  assign bus.busy_o       = (state_q == ISSUE);
  assign bus.dbg_state_o  = state_q;
  assign bus.dbg_credit_o = credit_q;
endmodule

// File: doc/vsu_op_sched.md
VSU_OP_SCHED -- requirements
Module: vsu_op_sched

Interface
Parameters
REQ-001 SHALL have parameter NrLane, default 4, number of lanes feeding the VSU.
REQ-002 SHALL have parameter InOpBufDepth, default 4, depth of each VSU per-lane operand FIFO; initial credit count.
REQ-003 SHALL have parameter LaneWordB, default 8, bytes per lane VRF word; NrLane*LaneWordB is a power of two.
REQ-004 SHALL have parameter VlBWidth, default 16, width of byte-length fields.
REQ-005 SHALL have parameter IdWidth, default 3, instruction-ID width.

Ports
REQ-006 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  1  store request valid
- req_ready_o  out  1  request accepted when high with valid
- req_vs_i  in  5  source vreg
- req_vlB_i  in  VlBWidth  store byte length
- req_id_i  in  IdWidth  instruction ID
- rd_valid_o  out  NrLane  per-lane VRF read request
- rd_ready_i  in  NrLane  per-lane accesser ready
- rd_vreg_o  out  5  vreg for all lanes
- rd_off_o  out  NrLane x VlBWidth  per-lane word offset
- op_pop_i  in  NrLane  VSU popped one entry from lane FIFO (credit return)
- issue_done_o  out  1  one-cycle pulse: all reads of current instruction issued
- issue_id_o  out  IdWidth  ID of the instruction in issue_done_o
- busy_o  out  1  high in ISSUE

Function
REQ-007 SHALL have states IDLE and ISSUE; req_ready_o=1 in IDLE.
REQ-008 On IDLE request handshake, SHALL latch vs, id, rows = ceil(vlB/(NrLane*LaneWordB)) computed at VlBWidth+1 bits, clear all lane row counters, go to ISSUE.
REQ-009 In ISSUE, rd_valid_o[i] SHALL equal (row[i] < rows) && (credit[i] != 0); rd_off_o[i]=row[i]; rd_vreg_o=latched vs.
REQ-010 rd_valid_o SHALL not depend combinationally on rd_ready_i; lanes progress independently.
REQ-011 On rd_valid_o[i]&&rd_ready_i[i], row[i] SHALL increment next cycle.
REQ-012 credit[i] SHALL decrement on lane-i read handshake, increment on op_pop_i[i], unchanged when both occur in one cycle, never exceed InOpBufDepth; credits persist across instructions.
REQ-013 When all row[i]==rows in ISSUE (registered compare), issue_done_o=1 and issue_id_o=latched id for that cycle only, with req_ready_o=1.
REQ-014 In that cycle, a request handshake SHALL load the new instruction and stay in ISSUE (no bubble); otherwise go to IDLE.
REQ-015 vlB=0 SHALL give rows=0: no rd_valid_o; issue_done_o in the first ISSUE cycle.
REQ-016 req_ready_o SHALL be 0 in ISSUE except in the issue_done_o cycle.
REQ-017 busy_o SHALL be 1 exactly when state is ISSUE.

Reset
REQ-018 On rst_ni low, SHALL enter IDLE asynchronously: req_ready_o=1, rd_valid_o=0, issue_done_o=0, busy_o=0, rows and row counters 0, all credits=InOpBufDepth; reset mid-ISSUE abandons the instruction.
REQ-019 Latched vs/id need no reset; rd_vreg_o and issue_id_o are don't-care while their valids are low.

Verification (NrLane=4, LaneWordB=8, Depth=4)
REQ-020 vlB=64, vs=3, rd_ready_i all 1 -> each lane handshakes off 0 then 1 on consecutive cycles; issue_done_o 1 cycle later; every credit=2.
REQ-021 vlB=256, no pops -> each lane issues offs 0-3, then rd_valid_o=0; one op_pop_i[2] pulse -> lane 2 issues off 4 next cycle only.
REQ-022 vlB=33 -> rows=2 (offs 0,1 per lane); vlB=0 -> no rd_valid_o, issue_done_o in first ISSUE cycle.
REQ-023 credit[1]=1, lane-1 handshake and op_pop_i[1] in same cycle -> credit[1] stays 1; rd_valid_o[1] stays high.
REQ-024 req_valid_i held (id=5, vs=7) through issue_done_o cycle -> accepted that cycle, next cycle rd_vreg_o=7, offs 0, later issue_id_o=5.
REQ-025 rst_ni low mid-ISSUE -> immediately rd_valid_o=0, busy_o=0, req_ready_o=1; after release credits=4.
